// File: rtl/alu_issue_buf.sv
// Two-entry issue buffer between decode and the ALU stage: a main entry
// driving out_* plus a skid entry, keeping in_ready independent of out_ready.
module alu_issue_buf #(
  parameter int DW  = 32,
  parameter int OPW = 3,
  parameter int WRW = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [DW-1:0]  in_a,
  input  logic [DW-1:0]  in_b,
  input  logic [OPW-1:0] in_op,
  input  logic [WRW-1:0] in_wreg,
  input  logic           flush,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DW-1:0]  out_a,
  output logic [DW-1:0]  out_b,
  output logic [OPW-1:0] out_op,
  output logic [WRW-1:0] out_wreg,
  output logic           out_illegal,
  output logic [15:0]    issue_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t         state_r, state_n_s;
  logic           in_ready_r, out_valid_r;
  logic [DW-1:0]  main_a_r, main_b_r, skid_a_r, skid_b_r;
  logic [OPW-1:0] main_op_r, skid_op_r;
  logic [WRW-1:0] main_wreg_r, skid_wreg_r;
  logic [15:0]    issue_cnt_r;
  logic           in_fire_s, out_fire_s;
  logic           load_main_in_s, load_main_skid_s, load_skid_s;

  // Legal op-codes are 000, 001, 010, 011, 110 and 111; anything else is flagged.
  function automatic logic op_illegal(input logic [OPW-1:0] op);
    logic ill;
    case (op)
      OPW'(3'd0), OPW'(3'd1), OPW'(3'd2),
      OPW'(3'd3), OPW'(3'd6), OPW'(3'd7): ill = 1'b0;
      default:                            ill = 1'b1;
    endcase
    return ill;
  endfunction

  assign in_fire_s  = in_valid & in_ready_r;
  assign out_fire_s = out_valid_r & out_ready;

  // Next-state and entry-load decode; flush wins over both handshakes.
  always_comb begin
    state_n_s        = state_r;
    load_main_in_s   = 1'b0;
    load_main_skid_s = 1'b0;
    load_skid_s      = 1'b0;
    if (flush) begin
      state_n_s = EMPTY;
    end else begin
      case (state_r)
        EMPTY: begin
          if (in_fire_s) begin
            load_main_in_s = 1'b1;
            state_n_s      = ONE;
          end else begin
            state_n_s = EMPTY;
          end
        end
        ONE: begin
          if (in_fire_s && out_fire_s) begin
            load_main_in_s = 1'b1;
            state_n_s      = ONE;
          end else if (in_fire_s) begin
            load_skid_s = 1'b1;
            state_n_s   = TWO;
          end else if (out_fire_s) begin
            state_n_s = EMPTY;
          end else begin
            state_n_s = ONE;
          end
        end
        TWO: begin
          if (out_fire_s) begin
            load_main_skid_s = 1'b1;
            state_n_s        = ONE;
          end else begin
            state_n_s = TWO;
          end
        end
        default: begin
          state_n_s = EMPTY;
        end
      endcase
    end
  end

  // State register with the handshake flags registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= EMPTY;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      state_r     <= state_n_s;
      out_valid_r <= (state_n_s != EMPTY);
      in_ready_r  <= (state_n_s != TWO);
    end
  end

  // Main entry: refilled from the input or promoted from skid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_a_r    <= {DW{1'b0}};
      main_b_r    <= {DW{1'b0}};
      main_op_r   <= {OPW{1'b0}};
      main_wreg_r <= {WRW{1'b0}};
    end else if (load_main_in_s) begin
      main_a_r    <= in_a;
      main_b_r    <= in_b;
      main_op_r   <= in_op;
      main_wreg_r <= in_wreg;
    end else if (load_main_skid_s) begin
      main_a_r    <= skid_a_r;
      main_b_r    <= skid_b_r;
      main_op_r   <= skid_op_r;
      main_wreg_r <= skid_wreg_r;
    end
  end

  // Skid entry: catches the second operation while main is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_a_r    <= {DW{1'b0}};
      skid_b_r    <= {DW{1'b0}};
      skid_op_r   <= {OPW{1'b0}};
      skid_wreg_r <= {WRW{1'b0}};
    end else if (load_skid_s) begin
      skid_a_r    <= in_a;
      skid_b_r    <= in_b;
      skid_op_r   <= in_op;
      skid_wreg_r <= in_wreg;
    end
  end

  // Delivered-operation counter; a delivery in a flush cycle still counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt_r <= 16'd0;
    end else if (out_fire_s) begin
      issue_cnt_r <= issue_cnt_r + 16'd1;
    end
  end

  assign in_ready    = in_ready_r;
  assign out_valid   = out_valid_r;
  assign out_a       = main_a_r;
  assign out_b       = main_b_r;
  assign out_op      = main_op_r;
  assign out_wreg    = main_wreg_r;
  assign out_illegal = out_valid_r & op_illegal(main_op_r);
  assign issue_cnt   = issue_cnt_r;

endmodule
